// File: rtl/sum_to_method_if.sv
//------------------------------------------------------------------------------
// sum_to_method_if
// Method-call handshake bundle for the sum_to method.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sum_to_method_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     sum_to_n;
  logic                 sum_to_req;
  logic                 sum_to_busy;
  logic [WIDTH-1:0]     sum_to_return;
  logic [CNT_WIDTH-1:0] call_count;

  modport master (
    output sum_to_n, sum_to_req,
    input  sum_to_busy, sum_to_return, call_count
  );

  modport slave (
    input  sum_to_n, sum_to_req,
    output sum_to_busy, sum_to_return, call_count
  );
endinterface

`default_nettype wire

// File: rtl/sum_to_method.sv
//------------------------------------------------------------------------------
// sum_to_method
// Callee for sum_to(n): returns 1+2+...+n, one add per cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sum_to_method #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  wire logic      clk,
  input  wire logic      reset,
  sum_to_method_if.slave bus
);

  localparam logic [WIDTH-1:0]     c_ONE     = WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_acc,   w_acc_nxt;
  logic [WIDTH-1:0]     r_i,     w_i_nxt;
  logic [WIDTH-1:0]     r_ret,   w_ret_nxt;
  logic [CNT_WIDTH-1:0] r_cnt,   w_cnt_nxt;
  logic                 r_armed, w_armed_nxt;
  logic                 r_busy,  w_busy_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_i     <= '0;
      r_ret   <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_i     <= w_i_nxt;
      r_ret   <= w_ret_nxt;
      r_cnt   <= w_cnt_nxt;
      r_armed <= w_armed_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_i_nxt     = r_i;
    w_ret_nxt   = r_ret;
    w_cnt_nxt   = r_cnt;
    w_armed_nxt = r_armed;
    w_busy_nxt  = r_busy;

    unique case (r_state)
      S_IDLE: begin
        // A held-high request must fall once before it can start another call.
        if (bus.sum_to_req) begin
          if (r_armed) begin
            w_i_nxt     = bus.sum_to_n;
            w_acc_nxt   = '0;
            w_armed_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_RUN;
          end
        end else begin
          w_armed_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (r_i == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_acc_nxt = r_acc + r_i;
          w_i_nxt   = r_i - c_ONE;
        end
      end
      S_DONE: begin
        w_ret_nxt   = r_acc;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt + c_CNT_ONE;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.sum_to_busy   = r_busy;
  assign bus.sum_to_return = r_ret;
  assign bus.call_count    = r_cnt;

endmodule

`default_nettype wire

// File: doc/sum_to_method.md
Name: sum_to_method

Overview:
- Hand-written responder for the method-call handshake used by generated modules: `<m>_req` in, `<m>_busy` and `<m>_return` out.
- Implements one method, `sum_to(n)`, which returns 1+2+…+n computed iteratively at one add per cycle.
- It is the callee side of the protocol that simulation benches and caller FSMs drive.
- Used as a known-latency target for checking caller logic, and as the template for future hand-coded methods.

Parameters:
- WIDTH, 32: width of the argument, the accumulator and the return value.
- CNT_WIDTH, 16: width of the completed-call counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sum_to_n  in  WIDTH  method argument n, unsigned; sampled only when a call is accepted.
- sum_to_req  in  1  call request, level-sensitive, qualified by the arming rule below.
- sum_to_busy  out  1  registered; high from the cycle after acceptance until the result is published.
- sum_to_return  out  WIDTH  registered result; holds the last result while busy is low.
- call_count  out  CNT_WIDTH  number of completed calls; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, sum_to_busy=0, sum_to_return=0, call_count=0.
  - Internal acc=0 and i=0; armed=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - If sum_to_req=1 and armed=1 at edge t: latch i<=sum_to_n, acc<=0, armed<=0, busy<=1, state<=RUN.
  - busy is therefore high from cycle t+1.
  - If sum_to_req=0: armed<=1.
  - If sum_to_req=1 and armed=0: stay IDLE.
- RUN, each cycle:
  - If i==0: state<=DONE.
  - Otherwise: acc<=acc+i with modulo 2^WIDTH wrap, no saturation, no overflow flag; and i<=i-1.
- DONE: sum_to_return<=acc, busy<=0, call_count<=call_count+1, state<=IDLE. All three outputs update on the same edge.
- Latency: busy is high for exactly n+2 cycles (n+1 RUN cycles plus 1 DONE cycle). For n=0 that is 2 cycles.
- Arming:
  - armed is cleared when a call is accepted and set again only after sum_to_req is sampled low in IDLE.
  - A req held continuously high yields exactly one call.
  - After reset, armed=1, so a req already high starts a call immediately.
- Argument stability: sum_to_n and sum_to_req changes while busy=1 are ignored.
- Return stability:
  - sum_to_return does not change during RUN.
  - The previous value stays visible until the new result is published.
- Reset mid-call: immediately aborts the call to IDLE with all outputs at their reset values. No partial result is published and call_count is not incremented.
- Back-to-back calls:
  - With req dropped for one cycle, then raised: the req=0 cycle in IDLE re-arms, and the next req=1 cycle is accepted.
  - Minimum gap between busy falling and busy rising again is 2 cycles.
- There is no combinational path from any input to any output.

Test Plan:
- Assert reset for cycles 3–8, then n=10, req=1 for one cycle → busy rises the next cycle and stays high 12 cycles; return=55 on the edge busy falls; call_count=1.
- n=0, one-cycle req → busy high 2 cycles; return=0; the previous return (55) is held until that edge.
- Hold req=1 continuously, as a bench does, with n=4 → exactly one call; busy falls after 6 cycles with return=10; busy stays 0 for 20+ cycles; call_count increments once.
- Wrap: n=100000 → return=705082704 (5000050000 mod 2^32); busy high 100002 cycles.
- Change sum_to_n from 10 to 3 during busy → return still 55; then drop req 1 cycle, raise with n=3 → second call returns 6; call_count=2.
- Assert reset during RUN of an n=1000 call → busy=0, return=0 and call_count=0 at once. After release, with req held high, a new call starts the next cycle and completes correctly.
